xup_tff_counter_ctrl: RTL and testbench

- Controller that sequences a SIZE-bit toggle-flip-flop bank as a programmable modulo up/down counter.
- Each cycle it computes the toggle vector t = q ^ next_q and the bank enable, from a small run-control FSM.
- Supports start/stop/clear/load and a one-shot mode.
- Sits between switch/button front-end logic and display or timing logic on the board.

---
 rtl/xup_tff_ctrl_pkg.sv | 35 +++
 rtl/xup_tff_bank_arst.sv | 29 ++
 rtl/xup_tff_counter_ctrl.sv | 106 ++++++++++
 tb/tb_xup_tff_counter_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/xup_tff_ctrl_pkg.sv
// Purpose: shared constants for the TFF-bank counter controller and its bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package xup_tff_ctrl_pkg;

  // Run-control FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Count direction as presented on up_dn
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Decoded per-cycle command after priority resolution
  typedef struct packed {
    logic do_clear;
    logic do_load;
    logic do_stop;
    logic do_start;
  } ctrl_cmd_t;

  // Resolve clear > load > stop > start; exactly one bit (or none) survives.
  function automatic ctrl_cmd_t resolve_cmd(input logic clear_i, input logic load_i,
                                            input logic stop_i, input logic start_i);
    ctrl_cmd_t cmd;
    cmd.do_clear = clear_i;
    cmd.do_load  = load_i  & ~clear_i;
    cmd.do_stop  = stop_i  & ~clear_i & ~load_i;
    cmd.do_start = start_i & ~clear_i & ~load_i & ~stop_i;
    return cmd;
  endfunction

endpackage

// File: rtl/xup_tff_bank_arst.sv
// Purpose: SIZE-bit toggle-flip-flop bank; each bit flips where t is set and en is high.
// Latency: one clk edge from (en, t) to q.
// Backpressure: none; applies every enabled cycle.
module xup_tff_bank_arst
  import xup_tff_ctrl_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [SIZE-1:0] t,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] q_q;

  // Toggle the selected bits on enabled edges; async clear to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_q ^ t;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/xup_tff_counter_ctrl.sv
// Purpose: run-control FSM driving a TFF bank as a programmable modulo up/down counter.
// Latency: one clk edge from any control input to count/busy/done; tc one edge after the step.
// Backpressure: none; every input is sampled and acted on each cycle.
module xup_tff_counter_ctrl
  import xup_tff_ctrl_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            up_dn,
  input  logic            one_shot,
  input  logic [SIZE-1:0] limit,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            tc,
  output logic            done
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [1:0]      state_q, state_d;
  logic            tc_q, tc_d;
  logic            busy_q, done_q;
  logic [SIZE-1:0] count_q;
  logic [SIZE-1:0] count_d;
  logic [SIZE-1:0] tog_vec;
  logic            bank_en;
  logic [SIZE-1:0] step_up_val, step_dn_val;
  logic            term_up, term_dn;
  logic            step_term;
  ctrl_cmd_t       cmd;

  assign cmd = resolve_cmd(clear, load, stop, start);

  // Terminal-count detection: up treats anything at or past limit as the
  // wrap point, so an over-limit load_val still returns to 0 on the next up step.
  assign term_up     = (count_q >= limit);
  assign term_dn     = (count_q == '0);
  assign step_up_val = term_up ? '0 : (count_q + ONE);
  assign step_dn_val = term_dn ? limit : (count_q - ONE);
  assign step_term   = (up_dn == DIR_UP) ? term_up : term_dn;

  // Next count and next state from the priority-resolved command
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (cmd.do_clear) begin
      count_d = '0;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (cmd.do_load) begin
      count_d = load_val;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (cmd.do_stop) begin
      if (state_q == ST_RUN) state_d = ST_HOLD;
    end else if (cmd.do_start && (state_q != ST_RUN)) begin
      // Entering RUN never moves the count; the first step is the next cycle
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      count_d = (up_dn == DIR_UP) ? step_up_val : step_dn_val;
      tc_d    = step_term;
      if (step_term && one_shot) state_d = ST_DONE;
    end
  end

  // Bank only sees the bits that actually change this edge
  assign tog_vec = count_q ^ count_d;
  assign bank_en = (count_d != count_q);

  xup_tff_bank_arst #(
    .SIZE (SIZE)
  ) u_bank (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (bank_en),
    .t     (tog_vec),
    .q     (count_q)
  );

  // FSM state, terminal-count pulse and decoded status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_xup_tff_counter_ctrl.sv
module tb_xup_tff_counter_ctrl;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, stop, clear, load, up_dn, one_shot;
  logic [SIZE-1:0] load_val, limit;
  logic [SIZE-1:0] count;
  logic            busy, tc, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xup_tff_counter_ctrl #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .one_shot (one_shot),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  typedef struct {
    logic       start, stop, clear, load;
    logic [3:0] load_val;
    logic       up_dn, one_shot;
    logic [3:0] limit;
    logic [3:0] e_count;
    logic       e_busy, e_done, e_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic sp, input logic c, input logic l,
                        input logic [3:0] lv, input logic ud, input logic os, input logic [3:0] lim);
    start = s; stop = sp; clear = c; load = l;
    load_val = lv; up_dn = ud; one_shot = os; limit = lim;
  endtask

  task automatic check_out(input string tag, input logic [3:0] c, input logic b,
                           input logic d, input logic t);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".tc"},    32'(tc),    32'(t));
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 4'd0, 1, 0, 4'd9);
    reset_n = 1'b0;
    repeat (3) tick();
    check_out("reset", 4'd0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  function automatic void add(input logic s, input logic sp, input logic c, input logic l,
                              input logic [3:0] lv, input logic ud, input logic os,
                              input logic [3:0] lim, input logic [3:0] ec, input logic eb,
                              input logic ed, input logic et);
    vec_t v;
    v.start = s; v.stop = sp; v.clear = c; v.load = l; v.load_val = lv;
    v.up_dn = ud; v.one_shot = os; v.limit = lim;
    v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = et;
    vecs.push_back(v);
  endfunction

  // Reference model: plain integer counter with named run modes
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
  int m_mode, m_cnt, m_tc;

  function automatic void model_edge();
    int n_mode, n_cnt, n_tc;
    n_mode = m_mode; n_cnt = m_cnt; n_tc = 0;
    if (clear) begin
      n_cnt = 0;
      if (m_mode == M_DONE) n_mode = M_IDLE;
    end else if (load) begin
      n_cnt = int'(load_val);
      if (m_mode == M_DONE) n_mode = M_IDLE;
    end else if (stop) begin
      if (m_mode == M_RUN) n_mode = M_HOLD;
    end else if (start && m_mode != M_RUN) begin
      n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (up_dn) begin
        if (m_cnt + 1 > int'(limit)) begin n_cnt = 0; n_tc = 1; end
        else n_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin n_cnt = int'(limit); n_tc = 1; end
        else n_cnt = m_cnt - 1;
      end
      if (n_tc == 1 && one_shot) n_mode = M_DONE;
    end
    m_mode = n_mode; m_cnt = n_cnt; m_tc = n_tc;
  endfunction

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 4'd0, 1, 0, 4'd9);

    // ---- Table: start, up wrap at limit 9, then combined priority, hold, resume
    add(1, 0, 0, 0, 4'd0, 1, 0, 4'd9, 4'd0, 1, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 4'd0, 1, 0, 4'd9, 4'(k), 1, 0, 0);
    add(0, 0, 0, 0, 4'd0, 1, 0, 4'd9, 4'd0, 1, 0, 1);   // 9 -> 0, tc pulse
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, 4'd0, 1, 0, 4'd9, 4'(k), 1, 0, 0);
    add(0, 1, 1, 1, 4'd7, 1, 0, 4'd9, 4'd0, 1, 0, 0);   // clear wins over load/stop
    add(0, 1, 0, 0, 4'd7, 1, 0, 4'd9, 4'd0, 0, 0, 0);   // stop -> HOLD
    add(0, 0, 0, 0, 4'd7, 1, 0, 4'd9, 4'd0, 0, 0, 0);   // held
    add(1, 1, 0, 0, 4'd7, 1, 0, 4'd9, 4'd0, 0, 0, 0);   // stop beats start
    add(1, 0, 0, 0, 4'd7, 1, 0, 4'd9, 4'd0, 1, 0, 0);   // resume, no step
    add(0, 0, 0, 0, 4'd7, 1, 0, 4'd9, 4'd1, 1, 0, 0);
    add(0, 0, 0, 0, 4'd7, 0, 0, 4'd9, 4'd0, 1, 0, 0);   // direction flip
    add(0, 0, 0, 0, 4'd7, 0, 0, 4'd9, 4'd9, 1, 0, 1);   // down wrap 0 -> 9
    add(0, 0, 0, 0, 4'd7, 0, 0, 4'd9, 4'd8, 1, 0, 0);
    add(0, 0, 0, 1, 4'd12, 1, 0, 4'd9, 4'd12, 1, 0, 0); // load above limit
    add(0, 0, 0, 0, 4'd0, 1, 0, 4'd9, 4'd0, 1, 0, 1);   // up past limit wraps
    add(0, 0, 0, 1, 4'd12, 0, 0, 4'd9, 4'd12, 1, 0, 0);
    add(0, 0, 0, 0, 4'd0, 0, 0, 4'd9, 4'd11, 1, 0, 0);  // down from above limit

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].load,
             vecs[i].load_val, vecs[i].up_dn, vecs[i].one_shot, vecs[i].limit);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
                vecs[i].e_done, vecs[i].e_tc);
    end

    // ---- Down one-shot from 3 with limit 9
    do_reset();
    set_in(0, 0, 0, 1, 4'd3, 0, 1, 4'd9);
    tick();
    check_out("os_load", 4'd3, 0, 0, 0);
    set_in(1, 0, 0, 0, 4'd3, 0, 1, 4'd9);
    tick();
    check_out("os_start", 4'd3, 1, 0, 0);
    set_in(0, 0, 0, 0, 4'd3, 0, 1, 4'd9);
    tick(); check_out("os_2", 4'd2, 1, 0, 0);
    tick(); check_out("os_1", 4'd1, 1, 0, 0);
    tick(); check_out("os_0", 4'd0, 1, 0, 0);
    tick(); check_out("os_9", 4'd9, 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      tick(); check_out($sformatf("os_frz%0d", k), 4'd9, 0, 1, 0);
    end
    set_in(1, 0, 0, 0, 4'd3, 0, 0, 4'd9);
    tick(); check_out("os_restart", 4'd9, 1, 0, 0);
    set_in(0, 0, 1, 0, 4'd3, 0, 1, 4'd9);
    tick(); check_out("os_clear_run", 4'd0, 1, 0, 0);

    // ---- limit = 0 free-running
    do_reset();
    set_in(1, 0, 0, 0, 4'd0, 1, 0, 4'd0);
    tick(); check_out("l0_start", 4'd0, 1, 0, 0);
    set_in(0, 0, 0, 0, 4'd0, 1, 0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); check_out($sformatf("l0_run%0d", k), 4'd0, 1, 0, 1);
    end
    set_in(0, 0, 0, 0, 4'd0, 1, 1, 4'd0);
    tick(); check_out("l0_oneshot", 4'd0, 0, 1, 1);
    set_in(0, 0, 0, 1, 4'd5, 1, 1, 4'd0);
    tick(); check_out("l0_done_load", 4'd5, 0, 0, 0);

    // ---- limit = 15: 15 -> 0 toggles every bit
    do_reset();
    set_in(0, 0, 0, 1, 4'd14, 1, 0, 4'd15);
    tick();
    set_in(1, 0, 0, 0, 4'd0, 1, 0, 4'd15);
    tick(); check_out("l15_start", 4'd14, 1, 0, 0);
    set_in(0, 0, 0, 0, 4'd0, 1, 0, 4'd15);
    tick(); check_out("l15_15", 4'd15, 1, 0, 0);
    check("l15_toggle", 32'(dut.tog_vec), 32'hF);
    tick(); check_out("l15_wrap", 4'd0, 1, 0, 1);

    // ---- async reset between edges at count 6
    do_reset();
    set_in(1, 0, 0, 0, 4'd0, 1, 0, 4'd9);
    tick();
    set_in(0, 0, 0, 0, 4'd0, 1, 0, 4'd9);
    repeat (6) tick();
    check_out("ar_pre", 4'd6, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("ar_now", 4'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); check_out($sformatf("ar_hold%0d", k), 4'd0, 0, 0, 0);
    end
    reset_n = 1'b1;

    // ---- randomized stimulus against the reference model
    do_reset();
    m_mode = M_IDLE; m_cnt = 0; m_tc = 0;
    set_in(0, 0, 0, 0, 4'd0, 1, 0, 4'd9);
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 99) < 20);
      stop     = ($urandom_range(0, 99) < 8);
      clear    = ($urandom_range(0, 99) < 3);
      load     = ($urandom_range(0, 99) < 5);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 10) up_dn = ~up_dn;
      if ($urandom_range(0, 99) < 5)  one_shot = ~one_shot;
      if ($urandom_range(0, 99) < 4)  limit = 4'($urandom_range(0, 15));
      model_edge();
      tick();
      check_out($sformatf("rnd%0d", i), 4'(m_cnt), m_mode == M_RUN,
                m_mode == M_DONE, m_tc[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
